ibuf_ctrl: RTL

IBUF_CTRL -- requirements
Module: ibuf_ctrl

---
 rtl/uarch_pkg.sv | 25 ++
 rtl/ibuf_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/uarch_pkg.sv
// ============================================================================
//  Module      : uarch_pkg
//  Description : Shared micro-architecture widths, instruction-buffer
//                defaults and the buffered {pc, inst} entry type.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package uarch_pkg;

    localparam int PIPE_WIDTH    = 2;
    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_INST_BITS = 32;

    localparam int                       IBUF_DEPTH_DEF = 8;
    localparam logic [CPU_INST_BITS-1:0] NOP_INST_DEF   = 32'h0000_0013;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [CPU_INST_BITS-1:0] inst;
    } ibuf_entry_t;

endpackage

`default_nettype wire

// File: rtl/ibuf_ctrl.sv
// ============================================================================
//  Module      : ibuf_ctrl
//  Description : Circular instruction buffer between fetch and decode that
//                presents instruction pairs, padding a lone entry with a NOP.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ibuf_ctrl
    import uarch_pkg::*;
#(
    parameter int                       IBUF_DEPTH = IBUF_DEPTH_DEF,
    parameter logic [CPU_INST_BITS-1:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      flush,
    input  logic                                      fetch_val,
    input  logic [PIPE_WIDTH-1:0]                     fetch_mask,
    input  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  fetch_pcs,
    input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  fetch_insts,
    output logic                                      ibuf_rdy,
    input  logic                                      decode_rdy,
    output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0]  inst_pcs,
    output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0]  insts,
    output logic                                      dec_val,
    output logic [$clog2(IBUF_DEPTH):0]               occupancy
);

    localparam int                 c_PTR_W = $clog2(IBUF_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(IBUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_WIDTH = c_CNT_W'(PIPE_WIDTH);

    ibuf_entry_t        r_mem [IBUF_DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_enq;
    logic               w_deq;
    logic [c_CNT_W-1:0] w_enq_n;
    logic [c_CNT_W-1:0] w_deq_n;
    logic [c_CNT_W-1:0] w_add;
    logic [c_CNT_W-1:0] w_sub;
    logic [c_PTR_W-1:0] w_wr_ofs [PIPE_WIDTH];

    // Credit is taken from the registered count only, so a pop this cycle
    // never frees space for a beat offered in the same cycle.
    assign ibuf_rdy  = (c_DEPTH - r_count) >= c_WIDTH;
    assign dec_val   = (r_count != '0);
    assign occupancy = r_count;

    assign w_enq   = fetch_val && ibuf_rdy && !flush;
    assign w_deq   = dec_val && decode_rdy && !flush;
    assign w_deq_n = (r_count >= c_WIDTH) ? c_WIDTH : r_count;
    assign w_add   = w_enq ? w_enq_n : '0;
    assign w_sub   = w_deq ? w_deq_n : '0;

    // Each valid slot lands at tail plus the number of valid slots below it,
    // which packs sparse masks into consecutive entries.
    always_comb begin
        w_enq_n = '0;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            w_wr_ofs[i] = w_enq_n[c_PTR_W-1:0];
            w_enq_n     = w_enq_n + c_CNT_W'(fetch_mask[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            inst_pcs[i] = '0;
            insts[i]    = '0;
            if (r_count > c_CNT_W'(i)) begin
                inst_pcs[i] = r_mem[r_head + c_PTR_W'(i)].pc;
                insts[i]    = r_mem[r_head + c_PTR_W'(i)].inst;
            end else if (dec_val) begin
                inst_pcs[i] = r_mem[r_head].pc + CPU_ADDR_BITS'(4 * i);
                insts[i]    = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + w_enq_n[c_PTR_W-1:0];
            end
            if (w_deq) begin
                r_head <= r_head + w_deq_n[c_PTR_W-1:0];
            end
            r_count <= r_count + w_add - w_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_enq) begin
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                if (fetch_mask[i]) begin
                    r_mem[r_tail + w_wr_ofs[i]] <= '{pc: fetch_pcs[i], inst: fetch_insts[i]};
                end
            end
        end
    end

endmodule

`default_nettype wire
